// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART transmit scheduler.
`default_nettype none

package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; on contention the requester
// that was not served last wins.
`default_nettype none

module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_idx
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_idx = ~i_last;
    end else begin
      o_idx = i_req1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between two byte requesters,
// issuing one byte at a time and waiting (bounded) for the frame to finish.
`default_nettype none

module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic              CP,
  input  logic              RST,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              grant,
  output logic              timeout_err
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              r_last;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_tx_en;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_busy;
  logic              r_grant;
  logic              r_timeout_err;

  logic              w_arb_valid;
  logic              w_arb_idx;
  logic              w_take;
  logic              w_wait_done;
  logic              w_wait_to;

  rr_arb2 u_arb (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_last  (r_last),
    .o_valid (w_arb_valid),
    .o_idx   (w_arb_idx)
  );

  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_take      = (r_state == IDLE) && w_arb_valid;
  assign w_wait_done = (r_state == WAIT) && tx_done;
  // Completion on the same edge as the limit counts as done, not timeout.
  assign w_wait_to   = (r_state == WAIT) && !tx_done && (w_cnt_inc == TIMEOUT_C);

  always_ff @(posedge CP or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_arb_valid) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_wait_done || w_wait_to) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the transition, so they line up with the new state.
  always_ff @(posedge CP or negedge RST) begin
    if (!RST) begin
      r_tx_en       <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_tx_data     <= '0;
      r_busy        <= 1'b0;
      r_grant       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_en       <= w_take;
      r_ack0        <= w_take && !w_arb_idx;
      r_ack1        <= w_take && w_arb_idx;
      r_busy        <= (w_next != IDLE);
      r_timeout_err <= w_wait_to;
      if (w_take) begin
        r_grant   <= w_arb_idx;
        r_tx_data <= w_arb_idx ? data1 : data0;
      end
    end
  end

  // Pointer starts at 1 so requester 0 wins the first contention after reset.
  always_ff @(posedge CP or negedge RST) begin
    if (!RST) begin
      r_cnt  <= '0;
      r_last <= 1'b1;
    end else begin
      if (r_state == ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_wait_done || w_wait_to) begin
        r_last <= r_grant;
      end
    end
  end

  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign tx_en       = r_tx_en;
  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign grant       = r_grant;
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed checks of arbitration, issue timing, timeout,
// reset abort and stray-done handling.
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int DW = 8;

  logic          CP;
  logic          RST;
  logic          req0;
  logic          req1;
  logic [DW-1:0] data0;
  logic [DW-1:0] data1;
  logic          ack0;
  logic          ack1;
  logic          tx_en;
  logic [DW-1:0] tx_data;
  logic          tx_done;
  logic          busy;
  logic          grant;
  logic          timeout_err;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_scheduler #(.DATA_W(DW), .TIMEOUT(15)) dut (
    .CP          (CP),
    .RST         (RST),
    .req0        (req0),
    .req1        (req1),
    .data0       (data0),
    .data1       (data1),
    .ack0        (ack0),
    .ack1        (ack1),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  // Packs all outputs: {timeout_err, grant, busy, tx_en, ack1, ack0, tx_data}
  function automatic logic [31:0] outs();
    return {18'd0, timeout_err, grant, busy, tx_en, ack1, ack0, tx_data};
  endfunction

  function automatic logic [31:0] pack(input logic te, input logic g, input logic b,
                                       input logic en, input logic a1, input logic a0,
                                       input logic [7:0] d);
    return {18'd0, te, g, b, en, a1, a0, d};
  endfunction

  task automatic finish_wait();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    RST = 1'b0; req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0; tx_done = 1'b0;
    tick(); tick();
    check("reset_outs", outs(), pack(0, 0, 0, 0, 0, 0, 8'h00));
    RST = 1'b1;
    tick();
    check("idle_after_reset", outs(), pack(0, 0, 0, 0, 0, 0, 8'h00));

    // Contention right after reset: req0 first, req1 two edges after done.
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h42; data1 = 8'h23;
    tick();
    check("cont_issue0", outs(), pack(0, 0, 1, 1, 0, 1, 8'h42));
    req0 = 1'b0;
    tick();
    check("cont_wait0", outs(), pack(0, 0, 1, 0, 0, 0, 8'h42));
    tick();
    finish_wait();
    check("cont_idle", outs(), pack(0, 0, 0, 0, 0, 0, 8'h42));
    tick();
    check("cont_issue1", outs(), pack(0, 1, 1, 1, 1, 0, 8'h23));
    req1 = 1'b0;
    tick();
    finish_wait();
    check("cont_done1", outs(), pack(0, 1, 0, 0, 0, 0, 8'h23));

    // Fairness: both held high for four transfers.
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hA0; data1 = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fair_grant", {31'd0, grant}, i % 2);
      check("fair_issue", {29'd0, tx_en, ack1, ack0},
            (i % 2) ? 32'b110 : 32'b101);
      check("fair_data", {24'd0, tx_data}, (i % 2) ? 32'hB1 : 32'hA0);
      tick();
      finish_wait();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Single request, with a tx_done during ISSUE that must be ignored.
    req0 = 1'b1; data0 = 8'h42;
    tick();
    check("single_issue", outs(), pack(0, 0, 1, 1, 0, 1, 8'h42));
    req0 = 1'b0; tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("done_in_issue_ignored", outs(), pack(0, 0, 1, 0, 0, 0, 8'h42));
    tick(); tick();
    check("single_busy_held", {31'd0, busy}, 32'd1);
    finish_wait();
    check("single_done", {31'd0, busy}, 32'd0);

    // Timeout: 15 WAIT cycles, then one timeout_err pulse.
    req1 = 1'b1; data1 = 8'h5A;
    tick();
    check("to_issue", outs(), pack(0, 1, 1, 1, 1, 0, 8'h5A));
    req1 = 1'b0;
    tick();
    for (int i = 1; i < 15; i++) begin
      tick();
      check("to_wait", {30'd0, busy, timeout_err}, 32'b10);
      check("to_hold_data", {24'd0, tx_data}, 32'h5A);
    end
    tick();
    check("to_pulse", outs(), pack(1, 1, 0, 0, 0, 0, 8'h5A));
    tick();
    check("to_pulse_end", {31'd0, timeout_err}, 32'd0);

    // Pointer advanced by timeout (last=1), so req0 wins contention.
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
    tick();
    check("to_ptr_grant", {31'd0, grant}, 32'd0);
    check("to_ptr_data", {24'd0, tx_data}, 32'h11);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    finish_wait();

    // Reset mid-WAIT: immediate clear, no pulses, then normal service.
    req1 = 1'b1; data1 = 8'h3C;
    tick();
    req1 = 1'b0;
    tick(); tick();
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    RST = 1'b0;
    #1;
    check("rst_async_clear", outs(), pack(0, 0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_held", outs(), pack(0, 0, 0, 0, 0, 0, 8'h00));
    end
    RST = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("rst_no_pulse", outs(), pack(0, 0, 0, 0, 0, 0, 8'h00));
    end
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h77; data1 = 8'h88;
    tick();
    check("rst_resume", outs(), pack(0, 0, 1, 1, 0, 1, 8'h77));
    req0 = 1'b0; req1 = 1'b0;
    tick();
    finish_wait();

    // Stray done in IDLE with no request.
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("stray_done", outs(), pack(0, 0, 0, 0, 0, 0, 8'h77));
    tick();
    check("stray_done_after", outs(), pack(0, 0, 0, 0, 0, 0, 8'h77));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
